// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: captures a multi-nibble value and drives seven-segment
// patterns (active-low, bit6=a .. bit0=g) both in parallel and as a
// time-multiplexed scan, with leading-zero blanking and per-digit blinking.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 24,
    parameter int SCAN_DIV   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic [6:0]              scan_seg,
    output logic [NUM_DIGITS-1:0]   scan_an,
    output logic                    upd
);

    localparam int               IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] hold_q,     hold_d;
    logic [BLINK_DIV-1:0]    blinkCnt_q, blinkCnt_d;
    logic [SCAN_DIV-1:0]     scanPre_q,  scanPre_d;
    logic [IDX_W-1:0]        scanIdx_q,  scanIdx_d;
    logic [7*NUM_DIGITS-1:0] seg_q,      seg_d;
    logic [6:0]              scanSeg_q,  scanSeg_d;
    logic [NUM_DIGITS-1:0]   scanAn_q,   scanAn_d;
    logic                    loadDly_q,  loadDly_d;
    logic                    upd_q,      upd_d;

    logic                    upperZero;
    logic [NUM_DIGITS-1:0]   digitBlank;
    logic [6:0]              digitPat [NUM_DIGITS];

    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    hexToSeg = 7'b0000001;
            4'h1:    hexToSeg = 7'b1001111;
            4'h2:    hexToSeg = 7'b0010010;
            4'h3:    hexToSeg = 7'b0000110;
            4'h4:    hexToSeg = 7'b1001100;
            4'h5:    hexToSeg = 7'b0100100;
            4'h6:    hexToSeg = 7'b0100000;
            4'h7:    hexToSeg = 7'b0001111;
            4'h8:    hexToSeg = 7'b0000000;
            4'h9:    hexToSeg = 7'b0001100;
            4'hA:    hexToSeg = 7'b0001000;
            4'hB:    hexToSeg = 7'b1100000;
            4'hC:    hexToSeg = 7'b0110001;
            4'hD:    hexToSeg = 7'b1000010;
            4'hE:    hexToSeg = 7'b0110000;
            default: hexToSeg = 7'b0111000;
        endcase
    endfunction

    // Walk from the top digit down so a digit blanks only when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        upperZero  = 1'b1;
        digitBlank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upperZero     = upperZero & (hold_q[4*k +: 4] == 4'h0);
            digitBlank[k] = (blank_lz & upperZero & (k != 0))
                          | (blinkCnt_q[BLINK_DIV-1] & blink_mask[k]);
        end
    end

    // Per-digit pattern with blanking applied, shared by the parallel and scan outputs.
    always_comb begin
        seg_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digitPat[k]      = digitBlank[k] ? SEG_BLANK : hexToSeg(hold_q[4*k +: 4]);
            seg_d[7*k +: 7]  = digitPat[k];
        end
    end

    // Scan outputs come from the same index value so anode and segments always switch together.
    always_comb begin
        scanSeg_d = digitPat[scanIdx_q];
        scanAn_d  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            scanAn_d[k] = (scanIdx_q != IDX_W'(k));
        end
    end

    // Counters, hold capture and the two-stage load delay feeding upd.
    always_comb begin
        blinkCnt_d = blinkCnt_q + BLINK_DIV'(1);
        scanPre_d  = scanPre_q + SCAN_DIV'(1);
        scanIdx_d  = scanIdx_q;
        if (&scanPre_q) begin
            scanIdx_d = (scanIdx_q == LAST_IDX) ? '0 : scanIdx_q + IDX_W'(1);
        end
        hold_d    = load ? data_in : hold_q;
        loadDly_d = load;
        upd_d     = loadDly_q;
    end

    // All state and registered outputs; reset shows a fully dark display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            blinkCnt_q <= '0;
            scanPre_q  <= '0;
            scanIdx_q  <= '0;
            seg_q      <= '1;
            scanSeg_q  <= '1;
            scanAn_q   <= '1;
            loadDly_q  <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            blinkCnt_q <= blinkCnt_d;
            scanPre_q  <= scanPre_d;
            scanIdx_q  <= scanIdx_d;
            seg_q      <= seg_d;
            scanSeg_q  <= scanSeg_d;
            scanAn_q   <= scanAn_d;
            loadDly_q  <= loadDly_d;
            upd_q      <= upd_d;
        end
    end

    assign seg      = seg_q;
    assign scan_seg = scanSeg_q;
    assign scan_an  = scanAn_q;
    assign upd      = upd_q;

endmodule
